div_check_mul: RTL
==================

Name: div_check_mul

Overview:
- Sequential shift-add multiply-accumulate unit. Computes P = Q*D + R. This is the inverse of the team's restoring divider.
- Takes a quotient (W bits), a divisor (W bits) and a remainder (W+1 bits), and rebuilds the 2W-bit dividend.
- Used as the reconstruction/checker stage after the divider, and standalone as a small multiplier.
- One control FSM plus datapath in one module; start/done handshake; W iteration cycles.

Parameters:
- W, 6, quotient/divisor width; remainder is W+1 bits, product is 2W bits.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; accepted only when busy=0.
- q_in  input  W  quotient (multiplier).
- d_in  input  W  divisor (multiplicand).
- r_in  input  W+1  remainder (addend).
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse; result valid.
- p_out  output  2W  reconstructed dividend, lower 2W bits of Q*D+R.
- ovf  output  1  bit 2W of the full sum; result did not fit.
- rem_lt_d  output  1  1 iff d_in != 0 and r_in < d_in, captured at load.

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, p_out=0, ovf=0, rem_lt_d=0; internal acc, mcand, mplier and counter cleared.
- States: IDLE, RUN, DONE.
- IDLE: at an edge with start=1:
  - mcand <= {0,d_in}, zero-extended to 2W+1.
  - mplier <= q_in.
  - acc <= {0,r_in}, zero-extended to 2W+1.
  - cnt <= 0; rem_lt_d <= (d_in!=0 && r_in<d_in); next state RUN.
  - Operand inputs are sampled only at this edge; later changes are ignored.
- RUN, each edge:
  - If mplier[0]=1: acc <= acc + mcand. All 2W+1 bits kept; cannot wrap for W=6 (max 4096 < 8192).
  - mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
  - When cnt==W-1 on this edge: next state DONE, and p_out/ovf are loaded from the post-add acc value in the same edge.
- DONE: done=1, busy=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- Latency: start accepted at edge E0; iterations at E0+1 … E0+W; done high during the cycle following E0+W. Total W+1 cycles start-to-done.
- Back-to-back: start high in the DONE cycle is ignored (busy=1). Earliest new accept is the edge after returning to IDLE, i.e. done-to-next-start ≥1 cycle in IDLE.
- start while busy: ignored entirely; no restart, no operand reload.
- Output hold: p_out, ovf and rem_lt_d hold their values from DONE until the next completed operation's final RUN edge. rem_lt_d updates at the next accept edge. Mid-operation they show the previous result, except rem_lt_d, which already reflects the new operands.
- d_in=0: product term is 0, so p_out = r_in, rem_lt_d=0.
- q_in=0: p_out = r_in; all W cycles still run (fixed latency, no early exit).
- Reset mid-RUN: immediate abort to IDLE with all outputs cleared; no done pulse.
- Counter width: $clog2(W) bits, minimum 1.

Test Plan:
- Reset, then start with q=5, d=7, r=3 → done exactly 7 cycles after the accept edge; p_out=0x026 (38), ovf=0, rem_lt_d=1; busy high for 7 cycles.
- q=44, d=45, r=20 (divider output for 2000/45) → p_out=0x7D0, ovf=0, rem_lt_d=1.
- q=63, d=63, r=127 → sum 4096 → p_out=0x000, ovf=1, rem_lt_d=0.
- d=0, q=45, r=9 → p_out=9, rem_lt_d=0. Then q=0, d=12, r=5 → p_out=5, still 7-cycle latency.
- Start q=3, d=3, r=0; pulse start with q=1, d=1 at cycles 2 and 6 (during DONE) → those pulses ignored, p_out=9. Start held continuously → second accept occurs one cycle after DONE.
- Assert rst at cycle 3 of RUN → busy=0, p_out=0 immediately; no done pulse. New start after release computes correctly.

Source files
------------

// File: rtl/div_check_mul.sv
// Shift-add multiply-accumulate: rebuilds P = Q*D + R over W iterations.
// Used to check the restoring divider's output, and also as a small stand-alone multiplier.
module div_check_mul #(
  parameter int W = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   q_in,
  input  logic [W-1:0]   d_in,
  input  logic [W:0]     r_in,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p_out,
  output logic           ovf,
  output logic           rem_lt_d
);

  // state | meaning
  // IDLE  | waiting for start; last result held on the outputs
  // RUN   | one shift-add iteration per cycle, W cycles in total
  // DONE  | one-cycle done pulse; start is ignored here
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t           state_q, state_d;
  logic [2*W:0]     acc_q, acc_d;
  logic [2*W:0]     mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   p_q, p_d;
  logic             ovf_q, ovf_d;
  logic             rlt_q, rlt_d;
  logic [2*W:0]     sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
      ovf_q    <= 1'b0;
      rlt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      ovf_q    <= ovf_d;
      rlt_q    <= rlt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    ovf_d    = ovf_q;
    rlt_d    = rlt_q;
    sum      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{(W+1){1'b0}}, d_in};
          mplier_d = q_in;
          acc_d    = {{W{1'b0}}, r_in};
          cnt_d    = '0;
          rlt_d    = (d_in != '0) && (r_in < {1'b0, d_in});
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Final iteration publishes the post-add value in the same edge.
        if (cnt_q == CNT_LAST) begin
          p_d     = sum[2*W-1:0];
          ovf_d   = sum[2*W];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign p_out    = p_q;
  assign ovf      = ovf_q;
  assign rem_lt_d = rlt_q;

endmodule
